// File: rtl/draw_pkg.sv
// Shared types and constants for the box plotting path.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COL_W    = 3;

    localparam logic [COL_W-1:0] WHITE = 3'b111;
    localparam logic [COL_W-1:0] BLACK = 3'b000;

    typedef enum logic {
        IDLE,
        DRAW
    } plot_state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } box_req_t;

endpackage

// File: rtl/box_req_fifo.sv
// Synchronous request FIFO holding box origins; DEPTH must be a power of 2.
module box_req_fifo
    import draw_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  box_req_t                 wdata,
    output box_req_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    box_req_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/box_plotter.sv
// Rasterises queued box requests into single-pixel VGA writes, row-major.
// Optional macro BOX_BORDER_EN draws a black outline around each box.
module box_plotter
    import draw_pkg::*;
#(
    parameter int unsigned BOX_W    = 4,
    parameter int unsigned BOX_H    = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SCREEN_W = draw_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = draw_pkg::SCREEN_H
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   in_x,
    input  logic [Y_W-1:0]   in_y,
    input  logic [COL_W-1:0] in_colour,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
    localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);

    plot_state_t             state;
    plot_state_t             state_nx;
    logic [3:0]              cx;
    logic [3:0]              cy;
    logic [X_W-1:0]          base_x;
    logic [Y_W-1:0]          base_y;
    logic [COL_W-1:0]        colour_q;

    box_req_t                fifo_wdata;
    box_req_t                fifo_rdata;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;

    logic                    last_pixel;
    logic                    edge_pixel;
    logic [8:0]              px;
    logic [7:0]              py;

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign fifo_wdata = '{x: in_x, y: in_y, colour: in_colour};
    assign busy       = (state == DRAW) || (fifo_count != '0);

    box_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (fifo_wdata),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        fifo_pop   = 1'b0;
        last_pixel = 1'b0;
        edge_pixel = (cx == '0) || (cx == CX_LAST) || (cy == '0) || (cy == CY_LAST);
        px         = {1'b0, base_x} + {5'b0, cx};
        py         = {1'b0, base_y} + {4'b0, cy};
        plot       = 1'b0;
        done       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = DRAW;
                end
            end
            DRAW: begin
                // Clipped pixels still take their cycle; only the write strobe is suppressed.
                plot  = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
                vga_x = px[X_W-1:0];
                vga_y = py[Y_W-1:0];
`ifdef BOX_BORDER_EN
                vga_colour = edge_pixel ? BLACK : colour_q;
`else
                vga_colour = colour_q;
`endif
                if ((cx == CX_LAST) && (cy == CY_LAST)) begin
                    last_pixel = 1'b1;
                    done       = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx       <= '0;
            cy       <= '0;
            base_x   <= '0;
            base_y   <= '0;
            colour_q <= '0;
        end else if (fifo_pop) begin
            cx       <= '0;
            cy       <= '0;
            base_x   <= fifo_rdata.x;
            base_y   <= fifo_rdata.y;
            colour_q <= fifo_rdata.colour;
        end else if (state == DRAW) begin
            if (last_pixel) begin
                cx <= '0;
                cy <= '0;
            end else if (cx == CX_LAST) begin
                cx <= '0;
                cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_box_plotter.sv
// Bench for box_plotter: box start times are derived from accept times, each box then owns 16 cycles.
module tb_box_plotter;

    localparam int BOX_W = 4;
    localparam int BOX_H = 4;
    localparam int DEPTH = 16;
    localparam int NPIX  = BOX_W * BOX_H;

    logic       clk;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    box_plotter #(
        .BOX_W    (BOX_W),
        .BOX_H    (BOX_H),
        .DEPTH    (DEPTH),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int last_s = -1000;
    int acc_a[$];
    int box_s[$];
    int rx[$];
    int ry[$];
    int rc[$];
    bit acc_last = 0;
    int done_seen = 0;
    int plot_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_cycle();
        int n = edge_n;
        int cnt = 0;
        bit inb = 0;
        int k_in = 0;
        int i, cx, cy, px, py, col;
        bit exp_plot;
        for (int k = 0; k < acc_a.size(); k++) begin
            if (acc_a[k] <= n) cnt++;
            if (box_s[k] <= n) cnt--;
            if (box_s[k] <= n && n < box_s[k] + NPIX) begin
                inb = 1;
                k_in = k;
            end
        end
        chk("in_ready", in_ready, (cnt < DEPTH) ? 1 : 0);
        chk("busy", busy, (inb || cnt > 0) ? 1 : 0);
        if (done === 1'b1) done_seen++;
        if (plot === 1'b1) plot_seen++;
        if (!inb) begin
            chk("plot_idle", plot, 0);
            chk("done_idle", done, 0);
        end else begin
            i = n - box_s[k_in];
            cx = i % BOX_W;
            cy = i / BOX_W;
            px = rx[k_in] + cx;
            py = ry[k_in] + cy;
            exp_plot = (px < 160) && (py < 120);
            col = rc[k_in];
`ifdef BOX_BORDER_EN
            if (cx == 0 || cx == BOX_W - 1 || cy == 0 || cy == BOX_H - 1) col = 0;
`endif
            chk("plot", plot, exp_plot);
            chk("done", done, (i == NPIX - 1) ? 1 : 0);
            chk("vga_x", vga_x, px % 256);
            chk("vga_y", vga_y, py % 128);
            chk("vga_colour", vga_colour, col);
        end
    endtask

    task automatic tick();
        int s;
        acc_last = 0;
        if (resetn && in_valid && in_ready) begin
            acc_last = 1;
            s = edge_n + 2;
            if (last_s + NPIX > s) s = last_s + NPIX;
            acc_a.push_back(edge_n + 1);
            box_s.push_back(s);
            rx.push_back(int'(in_x));
            ry.push_back(int'(in_y));
            rc.push_back(int'(in_colour));
            last_s = s;
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 800; i++) begin
            if (edge_n >= last_s + NPIX) break;
            tick();
        end
        chk("drain_bound", (edge_n >= last_s + NPIX) ? 1 : 0, 1);
        tick();
        tick();
    endtask

    task automatic rand_req();
        in_x      = 8'($urandom);
        in_y      = 7'($urandom);
        in_colour = 3'($urandom);
    endtask

    task automatic single(input int x, input int y, input int c);
        in_valid  = 1'b1;
        in_x      = 8'(x);
        in_y      = 7'(y);
        in_colour = 3'(c);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int k;
        bit saw_full;
        int d0, p0, first;

        resetn = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_colour = '0;
        #2;
        chk("rst_plot", plot, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_vga_colour", vga_colour, 0);
        @(negedge clk);
        resetn = 1'b1;

        // single box
        d0 = done_seen;
        single(43, 7, 7);
        drain();
        chk("single_done_count", done_seen - d0, 1);

        // 16 back-to-back requests
        d0 = done_seen;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            rand_req();
            tick();
            chk("burst_accept", acc_last, 1);
        end
        in_valid = 1'b0;
        drain();
        chk("burst_done_count", done_seen - d0, 16);

        // 20 requests held valid against backpressure
        saw_full = 0;
        k = 0;
        in_valid = 1'b1;
        rand_req();
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (in_ready === 1'b0) saw_full = 1;
            if (acc_last) begin
                k++;
                if (k == 20) break;
                rand_req();
            end
        end
        in_valid = 1'b0;
        chk("held_accepted", k, 20);
        chk("held_saw_full", saw_full, 1);
        d0 = done_seen;
        drain();

        // bottom-right clipping
        p0 = plot_seen;
        d0 = done_seen;
        single(158, 118, 2);
        drain();
        chk("clip_plot_count", plot_seen - p0, 4);
        chk("clip_done_count", done_seen - d0, 1);

        // outline / interior colours
        single(10, 10, 7);
        drain();

        // random traffic, source holds data while stalled
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || acc_last) begin
                in_valid = ($urandom_range(0, 3) == 0);
                rand_req();
            end
            tick();
        end
        in_valid = 1'b0;
        drain();

        // reset during the 5th pixel with 3 requests queued
        first = acc_a.size();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_x = 8'(20 + 8 * i);
            in_y = 7'(20);
            in_colour = 3'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (edge_n >= box_s[first] + 4) break;
            tick();
        end
        chk("pre_reset_plot", plot, 1);
        resetn = 1'b0;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        acc_a.delete();
        box_s.delete();
        rx.delete();
        ry.delete();
        rc.delete();
        last_s = -1000;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        resetn = 1'b1;
        p0 = plot_seen;
        d0 = done_seen;
        repeat (40) tick();
        chk("post_reset_plots", plot_seen - p0, 0);
        chk("post_reset_dones", done_seen - d0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/box_plotter.md
Name: box_plotter

Overview:
Consumes box-origin requests (x, y, colour) from the box sequencers, such as the per-player reset sequencer that emits one box per clock. It rasterises each request into a BOX_W x BOX_H block of single-pixel writes for the VGA adapter. A request FIFO absorbs bursts, since a sequencer can emit 16 boxes back-to-back while each box takes BOX_W*BOX_H cycles to draw.

Parameters:
BOX_W, 4, box width in pixels (1..16)
BOX_H, 4, box height in pixels (1..16)
DEPTH, 16, request FIFO entries (power of 2)
SCREEN_W, 160, pixel columns; x >= SCREEN_W is clipped
SCREEN_H, 120, pixel rows; y >= SCREEN_H is clipped

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  FIFO can accept; transfer on in_valid & in_ready at rising edge
in_x  in  8  box top-left x
in_y  in  7  box top-left y
in_colour  in  3  box colour
vga_x  out  8  pixel x to VGA adapter
vga_y  out  7  pixel y to VGA adapter
vga_colour  out  3  pixel colour
plot  out  1  write enable to VGA adapter
busy  out  1  high in DRAW or when FIFO is non-empty
done  out  1  one-cycle pulse during the last pixel cycle of each box

Behaviour:
- Reset state (resetn low, asynchronous): FIFO empty, state IDLE, cx = cy = 0, latched base/colour 0. Outputs: plot 0, done 0, busy 0, vga_x/vga_y/vga_colour 0, in_ready 1.
- FIFO:
  - in_ready = !full, evaluated from the registered count only. A pop in the same cycle does not raise in_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Entries leave in arrival order; none is lost or duplicated.
- FSM states: IDLE and DRAW.
  - IDLE: if the FIFO is non-empty, pop at the next edge, latch base_x/base_y/colour, set cx = cy = 0, go to DRAW.
  - DRAW: each cycle presents one pixel. cx increments; at BOX_W-1, cx wraps to 0 and cy increments.
  - On the pixel (BOX_W-1, BOX_H-1): done = 1. At that edge, if the FIFO is non-empty, pop and restart DRAW with no gap cycle; otherwise go to IDLE.
- Pixel outputs (combinational from registers, valid only in DRAW):
  - px = base_x + cx, computed 9-bit.
  - py = base_y + cy, computed 8-bit.
  - vga_x = px[7:0], vga_y = py[6:0], vga_colour = latched colour.
  - plot = 1 in DRAW unless px >= SCREEN_W or py >= SCREEN_H.
  - Clipped pixels still consume their cycle, so a box always takes exactly BOX_W*BOX_H cycles.
- Latency: a request accepted at edge T0 while IDLE with an empty FIFO enters DRAW at edge T1. The first plot is high in the cycle after T1.
- Outside DRAW, plot and done are 0.
- Reset mid-draw: asynchronous abort. The partial box is abandoned, no done pulse is issued, and queued entries are discarded.
- in_valid while in_ready is low: no transfer. The source must hold its data.

Optional Feature:
Macro BOX_BORDER_EN.
- Defined: pixels with cx == 0, cx == BOX_W-1, cy == 0 or cy == BOX_H-1 output vga_colour = 3'b000 (black outline). Interior pixels use the latched colour. Timing is unchanged.
- Undefined: every pixel uses the latched colour.

Decomposition:
- Package draw_pkg:
  - SCREEN_W = 160, SCREEN_H = 120
  - widths X_W = 8, Y_W = 7, COL_W = 3
  - colour constants WHITE = 3'b111, BLACK = 3'b000
  - FSM state enum plot_state_t {IDLE, DRAW}
  - packed struct box_req_t {x, y, colour} used as the FIFO word
- One sub-module: box_req_fifo, a synchronous DEPTH-entry FIFO with async active-low reset and push/pop/full/empty/count.

Test Plan:
- Single request (43, 7, 3'b111), defaults → 16 consecutive plot cycles, row-major x 43..46 by y 7..10, colour 111. done high only on (46, 10). busy low the cycle after.
- 16 requests on consecutive cycles (reset-sequencer pattern) → all accepted, no in_ready drop. 256 contiguous plot cycles with no gap between boxes. Boxes appear in request order. 16 done pulses.
- 20 requests held valid back-to-back → in_ready deasserts once count reaches 16 and reasserts after the next pop. Exactly 20 boxes are drawn in order, none duplicated.
- Request (158, 118, 3'b010) → 16 DRAW cycles. plot = 1 only for (158..159, 118..119), which is 4 pixels; 12 cycles have plot = 0. done still pulses.
- resetn low during the 5th pixel of a box with 3 queued requests → plot and done drop immediately. After release: in_ready 1, busy 0, no pixels ever emitted for the queued requests.
- With BOX_BORDER_EN defined and request (10, 10, 3'b111) → the 12 edge pixels have colour 000 and the 4 interior pixels (11..12, 11..12) have colour 111.
